mem_access_sequencer: RTL and testbench

- Parametrised sequencer for the shared-memory phases of LOADAC/STAC on the multi-core processor.
- Replaces the fixed four-core, per-core-state load/store walk with one generic per-core loop over NUM_CORES cores.
- Adds a per-core enable mask, a programmable wait-state count and a start/busy/done handshake toward the main control FSM.
- Sits between the control unit, which issues start and waits for done, and the per-core AR/DR/memory strobes.

---
 rtl/proc_pkg.sv | 21 ++
 rtl/core_pick.sv | 23 ++
 rtl/mem_access_sequencer.sv | 138 +++++++++++++
 tb/tb_mem_access_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the multi-core processor control path.
// Holds op encodings, the memory-sequencer state type and a width helper.
package proc_pkg;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WAIT  = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  // $clog2 that never returns 0, so single-value counters and one-core selects stay 1 bit wide.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_pick.sv
// Combinational find-first-set: reports the lowest set bit of vec and whether any bit is set.
module core_pick #(
  parameter int NUM_CORES = 4,
  parameter int CORE_W    = 2
) (
  input  logic [NUM_CORES-1:0] vec,
  output logic [CORE_W-1:0]    index,
  output logic                 found
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = CORE_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Walks the enabled cores in ascending order for the shared-memory phase of LOADAC/STAC,
// issuing address-setup, optional wait states and a load-capture or store strobe per core.
//
// state | meaning
// IDLE  | waiting for start; latches op and core_mask
// SETUP | address register load for the selected core
// WAIT  | WAIT_CYCLES settle cycles, down-counted
// XFER  | data transfer strobe; retire core, pick next
// DONE  | one-cycle completion pulse
module mem_access_sequencer
  import proc_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int CORE_W      = min1_clog2(NUM_CORES),
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op,
  input  logic [NUM_CORES-1:0] core_mask,
  output logic                 busy,
  output logic                 done,
  output logic [CORE_W-1:0]    core_sel,
  output logic                 sel_valid,
  output logic                 addr_we,
  output logic                 rd_capture,
  output logic                 mem_we
);

  localparam int WAIT_W = min1_clog2(WAIT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  seq_state_e state, state_next;

  logic                 op_q, op_next;
  logic [NUM_CORES-1:0] rem_mask, rem_mask_next;
  logic [WAIT_W-1:0]    wait_cnt, wait_cnt_next;

  logic [CORE_W-1:0]    pick_idx;
  logic                 pick_found;
  logic [NUM_CORES-1:0] cur_bit;
  logic [NUM_CORES-1:0] rem_after;

  // The current core is always the lowest bit still set in the remaining mask.
  core_pick #(
    .NUM_CORES (NUM_CORES),
    .CORE_W    (CORE_W)
  ) u_core_pick (
    .vec   (rem_mask),
    .index (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      cur_bit[i] = (pick_idx == CORE_W'(i));
    end
    rem_after = rem_mask & ~cur_bit;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_LOAD;
      rem_mask <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      op_q     <= op_next;
      rem_mask <= rem_mask_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    op_next       = op_q;
    rem_mask_next = rem_mask;
    wait_cnt_next = wait_cnt;
    busy          = 1'b0;
    done          = 1'b0;
    sel_valid     = 1'b0;
    addr_we       = 1'b0;
    rd_capture    = 1'b0;
    mem_we        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          op_next       = op;
          rem_mask_next = core_mask;
          state_next    = (|core_mask) ? SETUP : DONE;
        end
      end

      SETUP: begin
        busy          = 1'b1;
        sel_valid     = 1'b1;
        addr_we       = 1'b1;
        wait_cnt_next = WAIT_LOAD;
        state_next    = (WAIT_CYCLES > 0) ? WAIT : XFER;
      end

      WAIT: begin
        busy          = 1'b1;
        sel_valid     = 1'b1;
        wait_cnt_next = wait_cnt - WAIT_ONE;
        if (wait_cnt <= WAIT_ONE) begin
          state_next = XFER;
        end
      end

      XFER: begin
        busy          = 1'b1;
        sel_valid     = 1'b1;
        rd_capture    = (op_q == OP_LOAD);
        mem_we        = (op_q == OP_STORE);
        rem_mask_next = rem_after;
        state_next    = (|rem_after) ? SETUP : DONE;
      end

      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign core_sel = (sel_valid && pick_found) ? pick_idx : '0;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: a 4-core/1-wait and an 8-core/0-wait instance,
// with per-cycle expected output vectors queued at start and popped each cycle.
module tb_mem_access_sequencer;
  import proc_pkg::*;

  logic       clock;
  logic       reset;

  logic       start_a, op_a;
  logic [3:0] mask_a;
  logic       busy_a, done_a, sv_a, aw_a, rc_a, mw_a;
  logic [1:0] cs_a;

  logic       start_b, op_b;
  logic [7:0] mask_b;
  logic       busy_b, done_b, sv_b, aw_b, rc_b, mw_b;
  logic [2:0] cs_b;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];

  mem_access_sequencer #(.NUM_CORES(4), .WAIT_CYCLES(1)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .start      (start_a),
    .op         (op_a),
    .core_mask  (mask_a),
    .busy       (busy_a),
    .done       (done_a),
    .core_sel   (cs_a),
    .sel_valid  (sv_a),
    .addr_we    (aw_a),
    .rd_capture (rc_a),
    .mem_we     (mw_a)
  );

  mem_access_sequencer #(.NUM_CORES(8), .WAIT_CYCLES(0)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .start      (start_b),
    .op         (op_b),
    .core_mask  (mask_b),
    .busy       (busy_b),
    .done       (done_b),
    .core_sel   (cs_b),
    .sel_valid  (sv_b),
    .addr_we    (aw_b),
    .rd_capture (rc_b),
    .mem_we     (mw_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed view: {busy, done, sel_valid, core_sel[2:0], addr_we, rd_capture, mem_we}
  logic [8:0] obs_a, obs_b;
  assign obs_a = {busy_a, done_a, sv_a, 1'b0, cs_a, aw_a, rc_a, mw_a};
  assign obs_b = {busy_b, done_b, sv_b, cs_b, aw_b, rc_b, mw_b};

  function automatic logic [8:0] ev(input bit b, input bit d, input bit sv, input int cs,
                                    input bit aw, input bit rc, input bit mw);
    logic [2:0] c;
    c = cs[2:0];
    return {b, d, sv, c, aw, rc, mw};
  endfunction

  // Expected cycle-by-cycle trace, starting with the cycle after start is sampled.
  task automatic push_expected(input bit op_v, input logic [7:0] mask_v, input int n, input int w);
    for (int c = 0; c < n; c++) begin
      if (mask_v[c]) begin
        exp_q.push_back(ev(1, 0, 1, c, 1, 0, 0));
        for (int k = 0; k < w; k++) exp_q.push_back(ev(1, 0, 1, c, 0, 0, 0));
        exp_q.push_back(ev(1, 0, 1, c, 0, !op_v, op_v));
      end
    end
    exp_q.push_back(ev(1, 1, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic check(input string tag, input int cyc, input logic [8:0] obs, input logic [8:0] exp_v);
    logic [8:0] o;
    o = obs;
    if (!exp_v[6]) o[5:3] = 3'b000;
    checks++;
    assert (o === exp_v) else begin
      errors++;
      $error("FAIL %s cycle %0d: observed=%b expected=%b", tag, cyc, o, exp_v);
    end
  endtask

  task automatic drive(input bit use_b, input bit s, input bit o, input logic [7:0] m);
    if (use_b) begin
      start_b = s; op_b = o; mask_b = m;
    end else begin
      start_a = s; op_a = o; mask_a = m[3:0];
    end
  endtask

  // Called at a negedge while the selected DUT is idle; returns at the negedge of its first idle cycle.
  task automatic run_seq(input bit use_b, input bit op_v, input logic [7:0] mask_v,
                         input bit noise, input string tag);
    int n, w, last;
    logic [8:0] e;
    n = use_b ? 8 : 4;
    w = use_b ? 0 : 1;
    drive(use_b, 1'b1, op_v, mask_v);
    push_expected(op_v, mask_v, n, w);
    last = exp_q.size();
    @(negedge clock);
    for (int i = 1; i <= last; i++) begin
      if (noise && i == 2)             drive(use_b, 1'b1, !op_v, ~mask_v);
      else if (noise && i == last - 1) drive(use_b, 1'b1, !op_v, ~mask_v);
      else if (use_b)                  start_b = 1'b0;
      else                             start_a = 1'b0;
      e = exp_q.pop_front();
      check(tag, i, use_b ? obs_b : obs_a, e);
      if (i < last) @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] e;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    #1;
    check("reset_a", 0, obs_a, 9'b0);
    check("reset_b", 0, obs_b, 9'b0);
    @(negedge clock);
    reset = 1'b0;
    check("post_reset_a", 0, obs_a, 9'b0);

    run_seq(1'b0, OP_LOAD,  8'h0F, 1'b0, "t1_load_1111");
    run_seq(1'b0, OP_STORE, 8'h0A, 1'b0, "t2_store_1010");
    run_seq(1'b0, OP_LOAD,  8'h00, 1'b0, "t3_empty");
    run_seq(1'b1, OP_LOAD,  8'h81, 1'b0, "t4_n8_81");
    run_seq(1'b1, OP_STORE, 8'h3C, 1'b0, "t4_n8_3c");
    run_seq(1'b0, OP_LOAD,  8'h05, 1'b1, "t5_ignored_starts");
    run_seq(1'b0, OP_STORE, 8'h08, 1'b0, "t5_next_start");

    // Abort during the wait state of core 2.
    drive(1'b0, 1'b1, OP_LOAD, 8'h0F);
    push_expected(OP_LOAD, 8'h0F, 4, 1);
    @(negedge clock);
    start_a = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      e = exp_q.pop_front();
      check("t6_pre_reset", i, obs_a, e);
      if (i < 8) @(negedge clock);
    end
    exp_q.delete();
    #2 reset = 1'b1;
    #1 check("t6_async_reset", 8, obs_a, 9'b0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_no_done", i, obs_a, 9'b0);
      @(negedge clock);
    end
    run_seq(1'b0, OP_LOAD, 8'h01, 1'b0, "t6_fresh_start");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
